// File: rtl/fpu_div_sig_iter.sv
// Radix-2 restoring divider for single-precision significands.
// Slow-path FDIV datapath: sign, pre-round exponent, quotient and G/R/S.
module fpu_div_sig_iter #(
    parameter int MAN_W = 24,
    parameter int EXP_W = 10,
    parameter int BIAS  = 127,
    parameter int QBITS = MAN_W + 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_start,
    input  logic             sign_a,
    input  logic             sign_b,
    input  logic [EXP_W-1:0] exp_a,
    input  logic [EXP_W-1:0] exp_b,
    input  logic [MAN_W-1:0] sig_a,
    input  logic [MAN_W-1:0] sig_b,
    output logic             div_rdy,
    output logic             div_busy,
    output logic             q_sign,
    output logic [EXP_W-1:0] q_exp,
    output logic [MAN_W-1:0] q_sig,
    output logic [2:0]       q_grs
);

    localparam int CW = $clog2(QBITS);
    localparam int LO = QBITS - MAN_W;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        BUSY,
        NORM,
        DONE
    } state_t;

    state_t           state;
    logic [MAN_W:0]   rem;
    logic [MAN_W:0]   dvs;
    logic [QBITS-1:0] q;
    logic [CW-1:0]    cnt;
    logic             sgn_r;
    logic [EXP_W-1:0] ea_r;
    logic [EXP_W-1:0] eb_r;
    logic [EXP_W-1:0] exp_r;

    logic             ge;
    logic [MAN_W:0]   diff;
    logic [MAN_W:0]   rem_nx;
    logic             sticky;
    logic [MAN_W-1:0] n_sig;
    logic [2:0]       n_grs;
    logic [EXP_W-1:0] n_exp;

    always_comb begin
        ge     = rem >= dvs;
        diff   = rem - dvs;
        rem_nx = ge ? {diff[MAN_W-1:0], 1'b0}
                    : {rem[MAN_W-1:0], 1'b0};
    end

    // A zero divisor leaves an exact-looking remainder; force sticky
    always_comb begin
        sticky = (rem != '0) || (dvs == '0);
        n_sig  = '0;
        n_grs  = '0;
        n_exp  = exp_r;
        if (q[QBITS-1]) begin
            n_sig = q[QBITS-1:LO];
            n_grs = {q[LO-1], q[LO-2], q[0] | sticky};
            n_exp = exp_r;
        end else begin
            n_sig = q[QBITS-2:LO-1];
            n_grs = {q[LO-2], q[0], sticky};
            n_exp = exp_r - EXP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rem      <= '0;
            dvs      <= '0;
            q        <= '0;
            cnt      <= '0;
            sgn_r    <= 1'b0;
            ea_r     <= '0;
            eb_r     <= '0;
            exp_r    <= '0;
            div_rdy  <= 1'b0;
            div_busy <= 1'b0;
            q_sign   <= 1'b0;
            q_exp    <= '0;
            q_sig    <= '0;
            q_grs    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (div_start) begin
                        rem      <= {1'b0, sig_a};
                        dvs      <= {1'b0, sig_b};
                        q        <= '0;
                        cnt      <= '0;
                        sgn_r    <= sign_a ^ sign_b;
                        ea_r     <= exp_a;
                        eb_r     <= exp_b;
                        div_busy <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    // Exponent adder kept off the operand input path
                    exp_r <= ea_r - eb_r + EXP_W'(BIAS);
                    state <= BUSY;
                end
                BUSY: begin
                    rem <= rem_nx;
                    q   <= {q[QBITS-2:0], ge};
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(QBITS - 1)) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    q_sign  <= sgn_r;
                    q_exp   <= n_exp;
                    q_sig   <= n_sig;
                    q_grs   <= n_grs;
                    div_rdy <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    if (!div_start) begin
                        div_rdy  <= 1'b0;
                        div_busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_div_sig_iter.sv
// Bench for fpu_div_sig_iter: real-division reference model,
// per-cycle compare, literal vectors, reset abort and random traffic.
module tb_fpu_div_sig_iter;

    typedef struct packed {
        logic        s;
        logic [9:0]  e;
        logic [23:0] sig;
        logic [2:0]  grs;
    } res_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        div_start = 1'b0;
    logic        sign_a = 1'b0;
    logic        sign_b = 1'b0;
    logic [9:0]  exp_a = '0;
    logic [9:0]  exp_b = '0;
    logic [23:0] sig_a = '0;
    logic [23:0] sig_b = '0;
    logic        div_rdy;
    logic        div_busy;
    logic        q_sign;
    logic [9:0]  q_exp;
    logic [23:0] q_sig;
    logic [2:0]  q_grs;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    fpu_div_sig_iter dut (
        .clk       (clk),
        .reset     (reset),
        .div_start (div_start),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .exp_a     (exp_a),
        .exp_b     (exp_b),
        .sig_a     (sig_a),
        .sig_b     (sig_b),
        .div_rdy   (div_rdy),
        .div_busy  (div_busy),
        .q_sign    (q_sign),
        .q_exp     (q_exp),
        .q_sig     (q_sig),
        .q_grs     (q_grs)
    );

    always #5 clk = ~clk;

    // Quotient a/b scaled by 2^26, then normalised into 1.f with G/R/S
    function automatic res_t model(input logic sa, input logic sb,
                                   input logic [9:0] ea,
                                   input logic [9:0] eb,
                                   input logic [23:0] a,
                                   input logic [23:0] b);
        res_t r;
        longint num;
        longint n;
        longint rm;
        logic [9:0] e;
        e = ea - eb + 10'd127;
        r.s = sa ^ sb;
        if (b == 24'd0) begin
            r.e = e;
            r.sig = 24'hFFFFFF;
            r.grs = 3'b111;
        end else begin
            num = longint'(a) * 64'd67108864;
            n = num / longint'(b);
            rm = num % longint'(b);
            if (n >= 64'd67108864) begin
                r.e = e;
                r.sig = 24'(n >>> 3);
                r.grs = {n[2], n[1], n[0] | (rm != 0)};
            end else begin
                r.e = e - 10'd1;
                r.sig = 24'(n >>> 2);
                r.grs = {n[1], n[0], rm != 0};
            end
        end
        return r;
    endfunction

    logic m_busy = 1'b0;
    logic m_rdy = 1'b0;
    int   m_t = 0;
    res_t m_pend = '0;
    res_t m_vis = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0;
            m_rdy  <= 1'b0;
            m_t    <= 0;
            m_pend <= '0;
            m_vis  <= '0;
        end else if (!m_busy) begin
            if (div_start) begin
                m_busy <= 1'b1;
                m_t    <= 0;
                m_pend <= model(sign_a, sign_b, exp_a, exp_b,
                                sig_a, sig_b);
            end
        end else if (!m_rdy) begin
            m_t <= m_t + 1;
            if (m_t == 28) begin
                m_rdy <= 1'b1;
                m_vis <= m_pend;
            end
        end else if (!div_start) begin
            m_busy <= 1'b0;
            m_rdy  <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({div_rdy, div_busy, q_sign, q_exp, q_sig, q_grs}
                !== {m_rdy, m_busy, m_vis}) begin
                failures++;
                $display("FAIL cycle_cmp t=%0t got rdy=%b busy=%b res=%h exp rdy=%b busy=%b res=%h",
                         $time, div_rdy, div_busy,
                         {q_sign, q_exp, q_sig, q_grs},
                         m_rdy, m_busy, m_vis);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic scramble();
        logic [31:0] r0;
        logic [31:0] r1;
        r0 = $urandom;
        r1 = $urandom;
        sign_a = r0[0];
        sign_b = r0[1];
        exp_a = r0[11:2];
        exp_b = r0[21:12];
        sig_a = r1[23:0];
        sig_b = {r1[7:0], r0[31:16]};
    endtask

    task automatic launch(input logic sa, input logic sb,
                          input logic [9:0] ea, input logic [9:0] eb,
                          input logic [23:0] a, input logic [23:0] b,
                          input int hold,
                          output res_t got, output int lat);
        bit seen;
        @(negedge clk);
        sign_a = sa;
        sign_b = sb;
        exp_a = ea;
        exp_b = eb;
        sig_a = a;
        sig_b = b;
        div_start = 1'b1;
        @(posedge clk);
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (div_rdy) begin
                seen = 1'b1;
            end else begin
                scramble();
                @(posedge clk);
                lat++;
            end
        end
        got = {q_sign, q_exp, q_sig, q_grs};
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL rdy_timeout got=0 exp=1");
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
        end
        div_start = 1'b0;
    endtask

    res_t got;
    int   lat;

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_out", {div_rdy, div_busy, q_sign, q_exp, q_sig, q_grs}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        chk_en = 1'b1;

        launch(1'b0, 1'b0, 10'd127, 10'd127, 24'h800000, 24'h800000, 0, got, lat);
        chk("t1_lat", 64'(lat), 64'd29);
        chk("t1_res", 64'(got), {1'b0, 10'd127, 24'h800000, 3'b000});

        launch(1'b1, 1'b0, 10'd127, 10'd127, 24'hC00000, 24'h800000, 0, got, lat);
        chk("t2_res", 64'(got), {1'b1, 10'd127, 24'hC00000, 3'b000});

        launch(1'b0, 1'b0, 10'd127, 10'd127, 24'h800000, 24'hC00000, 0, got, lat);
        chk("t3_res", 64'(got), {1'b0, 10'd126, 24'hAAAAAA, 3'b101});

        launch(1'b1, 1'b1, 10'h338, 10'd300, 24'hA00000, 24'hA00000, 3, got, lat);
        chk("t4_res", 64'(got), {1'b0, 10'd651, 24'h800000, 3'b000});
        chk("t4_hold_rdy", 64'(div_rdy), 64'd1);
        @(negedge clk);
        chk("t4_idle", {62'd0, div_rdy, div_busy}, 64'd0);

        launch(1'b0, 1'b1, 10'd127, 10'd127, 24'h900000, 24'h000000, 0, got, lat);
        chk("zero_div_lat", 64'(lat), 64'd29);
        chk("zero_div_res", 64'(got), {1'b1, 10'd127, 24'hFFFFFF, 3'b111});

        @(negedge clk);
        sig_a = 24'hC00000;
        sig_b = 24'h800000;
        exp_a = 10'd127;
        exp_b = 10'd127;
        div_start = 1'b1;
        repeat (12) @(negedge clk);
        chk("t5_busy_pre", {62'd0, div_rdy, div_busy}, 64'd1);
        #2;
        reset = 1'b0;
        div_start = 1'b0;
        #1;
        chk("t5_abort", {div_rdy, div_busy, q_sign, q_exp, q_sig, q_grs}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        launch(1'b0, 1'b0, 10'd127, 10'd127, 24'h800000, 24'h800000, 0, got, lat);
        chk("t5_lat", 64'(lat), 64'd29);
        chk("t5_res", 64'(got), {1'b0, 10'd127, 24'h800000, 3'b000});

        for (int n = 0; n < 200; n++) begin
            logic [31:0] r0;
            logic [31:0] r1;
            logic [31:0] r2;
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            r0 = $urandom;
            r1 = $urandom;
            r2 = $urandom;
            launch(r0[0], r0[1], r0[11:2], r0[21:12],
                   {1'b1, r1[22:0]}, {1'b1, r2[22:0]}, 0, got, lat);
            chk("rnd_lat", 64'(lat), 64'd29);
        end

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
